noc_out_wormhole_arbiter: RTL

- Per-output-port arbiter for the NoC router. It shares one output channel (N/S/W/E/Local) among the router's input ports.
- Uses round-robin selection on head flits, then holds the grant (wormhole lock) until the tail flit transfers.
- Sits between the input buffers and the output mux. It drives the mux select and flags stalls and protocol violations.

---
 rtl/noc_out_wormhole_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/noc_out_wormhole_arbiter.sv
// Output-port arbiter for one NoC router channel: round-robin on head flits,
// wormhole lock held until the tail transfers, with a stall watchdog.
module noc_out_wormhole_arbiter #(
   parameter int NUM_REQ   = 5,
   parameter int IDX_W     = $clog2(NUM_REQ),
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = 255
) (
   input  logic               clk_noc,
   input  logic               arst_noc,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] head_i,
   input  logic [NUM_REQ-1:0] tail_i,
   input  logic               out_ready_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               locked_o,
   output logic               fwd_o,
   output logic [CNT_W-1:0]   pkt_cnt_o,
   output logic               stall_o,
   output logic               proto_err_o
);

   // state  | meaning
   // IDLE   | no packet owns the output; arbitrate among head flits
   // LOCKED | grant_idx_o owns the output until its tail transfers
   typedef enum logic {IDLE, LOCKED} state_t;

   localparam int SW = $clog2(STALL_MAX + 1);

   state_t             state, state_nxt;
   logic [NUM_REQ-1:0] grant_nxt, cand;
   logic [IDX_W-1:0]   idx_nxt, ptr, ptr_nxt, win_idx;
   logic               win_vld, take_win;
   logic               first_done, first_done_nxt;
   logic [CNT_W-1:0]   pkt_cnt_nxt;
   logic [SW-1:0]      stall_cnt, stall_cnt_nxt;
   logic               proto_err_nxt;
   logic               req_g, head_g, tail_g;
   int                 j;

   assign locked_o = (state == LOCKED);
   assign req_g    = req_i[grant_idx_o];
   assign head_g   = head_i[grant_idx_o];
   assign tail_g   = tail_i[grant_idx_o];
   assign fwd_o    = locked_o & req_g & out_ready_i;

   // The current holder is masked out: when it re-arbitrates it is presenting its tail.
   assign cand = req_i & head_i & (locked_o ? ~grant_o : {NUM_REQ{1'b1}});

   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      j       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!win_vld && cand[j]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(j);
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_o;
      idx_nxt        = grant_idx_o;
      ptr_nxt        = ptr;
      first_done_nxt = first_done;
      pkt_cnt_nxt    = pkt_cnt_o;
      stall_cnt_nxt  = stall_cnt;
      proto_err_nxt  = 1'b0;
      take_win       = 1'b0;
      case (state)
         IDLE: begin
            stall_cnt_nxt = '0;
            take_win      = win_vld;
         end
         LOCKED: begin
            if (fwd_o) begin
               stall_cnt_nxt  = '0;
               first_done_nxt = 1'b1;
               proto_err_nxt  = head_g & first_done;
               if (tail_g) begin
                  pkt_cnt_nxt = pkt_cnt_o + 1'b1;
                  if (win_vld) begin
                     take_win = 1'b1;
                  end else begin
                     state_nxt      = IDLE;
                     grant_nxt      = '0;
                     idx_nxt        = '0;
                     first_done_nxt = 1'b0;
                  end
               end
            end else if (!req_g && stall_cnt != SW'(STALL_MAX)) begin
               stall_cnt_nxt = stall_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (take_win) begin
         state_nxt      = LOCKED;
         grant_nxt      = NUM_REQ'(1) << win_idx;
         idx_nxt        = win_idx;
         ptr_nxt        = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         first_done_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_noc) begin
      if (!arst_noc) begin
         state       <= IDLE;
         grant_o     <= '0;
         grant_idx_o <= '0;
         ptr         <= '0;
         first_done  <= 1'b0;
         pkt_cnt_o   <= '0;
         stall_cnt   <= '0;
         stall_o     <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant_o     <= grant_nxt;
         grant_idx_o <= idx_nxt;
         ptr         <= ptr_nxt;
         first_done  <= first_done_nxt;
         pkt_cnt_o   <= pkt_cnt_nxt;
         stall_cnt   <= stall_cnt_nxt;
         stall_o     <= (stall_cnt_nxt == SW'(STALL_MAX));
         proto_err_o <= proto_err_nxt;
      end
   end

endmodule
